// File: rtl/unidade_controle_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, T0-T3 state encoding, bus sources.
// Optional feature macro: UC_SUB_EN (enables the sub instruction on opcode 011).
package unidade_controle_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } estado_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] BUS_RX  = 2'b00;
    localparam logic [1:0] BUS_RY  = 2'b01;
    localparam logic [1:0] BUS_DIN = 2'b10;
    localparam logic [1:0] BUS_G   = 2'b11;

    // Opcodes that take the three-cycle ALU path through A and G.
    function automatic logic is_alu_op(input logic [2:0] op);
`ifdef UC_SUB_EN
        return (op == OP_ADD) || (op == OP_SUB);
`else
        return (op == OP_ADD);
`endif
    endfunction

endpackage

// File: rtl/unidade_controle_decodificador_3x8.sv
// One-hot 3-to-8 decoder with enable; drives the register-bank write enables.
module decodificador_3x8 (
    input  logic [2:0] idx_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    // Single bit set at idx_i when enabled, all zero otherwise.
    always_comb begin
        onehot_o = 8'h00;
        if (en_i) begin
            onehot_o = 8'h01 << idx_i;
        end else begin
            onehot_o = 8'h00;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches a 9-bit IR and sequences mv/mvi/add/sub through T0-T3.
// Optional feature macro: UC_SUB_EN (opcode 011 executes sub; otherwise it is a NOP).
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] din,
    output logic [2:0]  rx,
    output logic [2:0]  ry,
    output logic [2:0]  regDestino,
    output logic [7:0]  regEnable,
    output logic [1:0]  busSel,
    output logic        aIn,
    output logic        gIn,
    output logic        addSub,
    output logic        done
);

    estado_t     state_q, state_d;
    logic [8:0]  ir_q, ir_d;
    logic [2:0]  ir_op_s, ir_x_s, ir_y_s;
    logic [2:0]  rx_s, ry_s;
    logic [1:0]  bus_s;
    logic        a_in_s, g_in_s, add_sub_s, done_s, wr_en_s, sub_sel_s;
    logic        unused_din_s;

    assign ir_op_s      = ir_q[8:6];
    assign ir_x_s       = ir_q[5:3];
    assign ir_y_s       = ir_q[2:0];
    assign unused_din_s = ^din[6:0];

`ifdef UC_SUB_EN
    assign sub_sel_s = (ir_op_s == OP_SUB);
`else
    assign sub_sel_s = 1'b0;
`endif

    // State and instruction register; reset returns to fetch with a cleared IR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control decode from state and IR.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        rx_s      = 3'd0;
        ry_s      = 3'd0;
        bus_s     = BUS_RX;
        a_in_s    = 1'b0;
        g_in_s    = 1'b0;
        add_sub_s = 1'b0;
        done_s    = 1'b0;
        wr_en_s   = 1'b0;
        case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din[15:7];
                    state_d = T1;
                end else begin
                    state_d = T0;
                end
            end
            T1: begin
                rx_s = ir_x_s;
                ry_s = ir_y_s;
                if (ir_op_s == OP_MV) begin
                    bus_s   = BUS_RY;
                    wr_en_s = 1'b1;
                    done_s  = 1'b1;
                    state_d = T0;
                end else if (ir_op_s == OP_MVI) begin
                    bus_s   = BUS_DIN;
                    wr_en_s = 1'b1;
                    done_s  = 1'b1;
                    state_d = T0;
                end else if (is_alu_op(ir_op_s)) begin
                    bus_s   = BUS_RX;
                    a_in_s  = 1'b1;
                    state_d = T2;
                end else begin
                    // Reserved opcode: complete immediately without touching the datapath.
                    done_s  = 1'b1;
                    state_d = T0;
                end
            end
            T2: begin
                rx_s      = ir_x_s;
                ry_s      = ir_y_s;
                bus_s     = BUS_RY;
                g_in_s    = 1'b1;
                add_sub_s = sub_sel_s;
                state_d   = T3;
            end
            T3: begin
                rx_s    = ir_x_s;
                ry_s    = ir_y_s;
                bus_s   = BUS_G;
                wr_en_s = 1'b1;
                done_s  = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    decodificador_3x8 u_dec (
        .idx_i    (ir_x_s),
        .en_i     (wr_en_s & ~reset),
        .onehot_o (regEnable)
    );

    // Reset gates every control output so no register write can happen in a reset cycle.
    assign rx         = reset ? 3'd0   : rx_s;
    assign ry         = reset ? 3'd0   : ry_s;
    assign regDestino = reset ? 3'd0   : ir_x_s;
    assign busSel     = reset ? BUS_RX : bus_s;
    assign aIn        = reset ? 1'b0   : a_in_s;
    assign gIn        = reset ? 1'b0   : g_in_s;
    assign addSub     = reset ? 1'b0   : add_sub_s;
    assign done       = reset ? 1'b0   : done_s;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 16-bit datapath. It captures an instruction word from `din`, sequences it through a fixed T0–T3 state machine and drives the control inputs of the 8×16 register bank directly upstream of it: register selects, destination index and one-hot write enables. It also drives the bus multiplexer, accumulator A and result register G around the ALU, and signals completion with `done`.

## Interface
- No parameters; widths are fixed by the register bank (16-bit data, 8 registers, 3-bit indices).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start request, sampled only in T0.
- `din` in 16: instruction word in T0; immediate operand in T1 of `mvi`.
- `rx` out 3: register-bank read select X; reset 0.
- `ry` out 3: register-bank read select Y; reset 0.
- `regDestino` out 3: destination index, always IR.X; reset 0.
- `regEnable` out 8: one-hot write enables, bit i → `r{i}Enable`; reset 0.
- `busSel` out 2: bus source, 00 = dadosRx, 01 = dadosRy, 10 = din, 11 = G; reset 00.
- `aIn` out 1: load A from bus; reset 0.
- `gIn` out 1: load G from ALU; reset 0.
- `addSub` out 1: ALU op, 0 = add, 1 = sub; reset 0.
- `done` out 1: instruction completes this cycle; reset 0.

## Operation
- IR is 9 bits, captured from `din[15:7]`: op = IR[8:6], X = IR[5:3], Y = IR[2:0]. `din[6:0]` is ignored.
- Opcodes:
  - 000 `mv Rx,Ry`
  - 001 `mvi Rx,#D`
  - 010 `add Rx,Ry`
  - 011 `sub Rx,Ry`
  - 100–111 reserved: executed as NOP.
- States: T0 (idle/fetch), T1, T2, T3, held in a 2-bit register.
- T0: when `run`=1, IR ← din[15:7] and go to T1; otherwise stay. All enables are 0.
- mv in T1: busSel=01, ry=Y, regEnable[X]=1, done=1 → T0.
- mvi in T1: busSel=10, regEnable[X]=1, done=1 → T0.
- add/sub in T1: busSel=00, rx=X, aIn=1 → T2.
- add/sub in T2: busSel=01, ry=Y, gIn=1, addSub=(op==011) → T3.
- add/sub in T3: busSel=11, regEnable[X]=1, done=1 → T0.
- Reserved opcode in T1: done=1 and no enables → T0.
- Outputs are combinational from state and IR. `rx`/`ry` hold IR.X/IR.Y outside T0 and hold 0 in T0.
- `regEnable` is at most one-hot in every cycle; the bench checks this as an assertion.

## Timing
- mv, mvi and NOP complete in 2 cycles: the `run` sample edge, then T1 with `done`.
- add and sub complete in 4 cycles: T0, T1, T2, T3.
- `done` is high for exactly one cycle per instruction.
- `run` is ignored outside T0. A `run` held high in the `done` cycle is not seen; it is sampled in the following T0 cycle, so back-to-back issue costs one T0 cycle.
- `reset` high forces every output to its reset value in the same cycle (combinational gate), so no register write can occur in a reset cycle. The next state is T0 and IR is cleared to 0.
- Reset mid-instruction aborts it: no write and no `done`.
- The register bank latches `dadosReg` during the cycle where `regEnable` is nonzero. `regDestino` is stable for the whole instruction.

## Configuration
- `UC_SUB_EN`
  - Defined: op 011 executes `sub` as above.
  - Undefined: op 011 is reserved (one-cycle NOP with `done`), and `addSub` is tied to 0.

## Structure
- `unidade_controle_pkg` holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - the state encoding T0–T3;
  - BUS_RX, BUS_RY, BUS_DIN, BUS_G.
- One sub-module, `decodificador_3x8`: 3-bit index plus enable in, one-hot 8-bit out. It is used to generate `regEnable` from X.

## Test plan
- Reset, then idle 5 cycles with `run`=0 → all outputs 0, state stays T0.
- `run`=1, din=16'h2480 (mvi R1), next-cycle din=16'h00AB → T1: busSel=10, regEnable=8'b0000_0010, done=1; R1=0x00AB.
- mv R3,R5 (din=16'h0E80) with R5=5 → one T1 cycle, ry=5, busSel=01, regEnable=8'h08, done; R3=5.
- add R2,R7 (din=16'h4B80) with R2=2, R7=7 → T1 aIn, T2 gIn/addSub=0, T3 regEnable=8'h04 with done; R2=9, done asserted only in cycle 4.
- sub R4,R1 (din=16'h7080) with R4=4, R1=1, `UC_SUB_EN` defined → R4=3. With the macro undefined → NOP, done in T1, R4 unchanged.
- `reset` asserted in T2 of an add → no regEnable and no done; T0 on the next edge; a following `run` starts cleanly.
